// File: rtl/snn_sched_pkg.sv
// Shared constants and packet format for the spike scheduler.
// Rows are indexed by time slot; packets carry axon and delay.
package snn_sched_pkg;

    localparam int NUM_AXONS  = 256;
    localparam int NUM_SLOTS  = 16;
    localparam int AXON_W     = 8;
    localparam int SLOT_W     = 4;
    localparam int FIFO_DEPTH = 4;

    // A delay of NUM_SLOTS-1 would wrap back onto the row being read
    localparam logic [SLOT_W-1:0] ILLEGAL_DELAY = SLOT_W'(NUM_SLOTS - 1);

    typedef struct packed {
        logic [AXON_W-1:0] axon;
        logic [SLOT_W-1:0] delay;
    } packet_t;

    // Row a packet lands in: one past the current slot plus its delay
    function automatic logic [SLOT_W-1:0] target_slot(
        input logic [SLOT_W-1:0] cur,
        input logic [SLOT_W-1:0] delay
    );
        return cur + SLOT_W'(1) + delay;
    endfunction

endpackage

// File: rtl/spike_packet_fifo.sv
// Small synchronous FIFO buffering spike packets ahead of the row array.
// Push is ignored when full and pop when empty.
module spike_packet_fifo
    import snn_sched_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  packet_t       din,
    input  logic          pop,
    output packet_t       dout,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    packet_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Packet storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spike_scheduler.sv
// Delay-line scheduler feeding axon spike vectors to the neuron grid.
// Packets drain into future rows; the grid snapshots and clears rows.
module spike_scheduler
    import snn_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 packet_valid,
    output logic                 packet_ready,
    input  logic [AXON_W-1:0]    packet_axon,
    input  logic [SLOT_W-1:0]    packet_delay,
    input  logic                 scheduler_set,
    input  logic                 scheduler_clr,
    output logic [NUM_AXONS-1:0] axon_spikes,
    output logic [SLOT_W-1:0]    current_slot,
    output logic [SLOT_W-1:0]    fifo_count,
    output logic                 error
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_AXONS-1:0] rows [NUM_SLOTS];
    packet_t              head;
    packet_t              pkt_in;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic                 pop_fire;
    logic                 illegal;
    logic [SLOT_W-1:0]    target;

    assign pkt_in       = '{axon: packet_axon, delay: packet_delay};
    assign packet_ready = !full;
    assign fifo_count   = SLOT_W'(count);
    assign pop_fire     = !empty && !tick;
    assign illegal      = (head.delay == ILLEGAL_DELAY);
    assign target       = target_slot(current_slot, head.delay);

    spike_packet_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (packet_valid),
        .din   (pkt_in),
        .pop   (!tick),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Row array: grid clears the current row, drains set future bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) rows[i] <= '0;
        end else begin
            if (scheduler_clr) rows[current_slot] <= '0;
            if (pop_fire && !illegal) rows[target][head.axon] <= 1'b1;
        end
    end

    // Snapshot of the current row, held until the next set
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              axon_spikes <= '0;
        else if (scheduler_set) axon_spikes <= rows[current_slot];
    end

    // Read pointer advances once per tick, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     current_slot <= '0;
        else if (tick) current_slot <= current_slot + SLOT_W'(1);
    end

    // Sticky flag for packets whose delay would hit the current row
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   error <= 1'b0;
        else if (pop_fire && illegal) error <= 1'b1;
    end

endmodule

// File: tb/tb_spike_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic,
// compared each cycle against a queue/array reference model.
module tb_spike_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tick = 1'b0;
    logic         packet_valid = 1'b0;
    logic         packet_ready;
    logic [7:0]   packet_axon = '0;
    logic [3:0]   packet_delay = '0;
    logic         scheduler_set = 1'b0;
    logic         scheduler_clr = 1'b0;
    logic [255:0] axon_spikes;
    logic [3:0]   current_slot;
    logic [3:0]   fifo_count;
    logic         error;

    int checks = 0;
    int errors = 0;

    logic [255:0] m_rows [16];
    logic [255:0] m_spk;
    int           m_slot;
    int           q_axon [$];
    int           q_delay [$];
    bit           m_err;

    spike_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .packet_valid  (packet_valid),
        .packet_ready  (packet_ready),
        .packet_axon   (packet_axon),
        .packet_delay  (packet_delay),
        .scheduler_set (scheduler_set),
        .scheduler_clr (scheduler_clr),
        .axon_spikes   (axon_spikes),
        .current_slot  (current_slot),
        .fifo_count    (fifo_count),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_rows[i] = '0;
        m_spk  = '0;
        m_slot = 0;
        m_err  = 1'b0;
        q_axon.delete();
        q_delay.delete();
    endtask

    task automatic compare_all();
        check("spikes", axon_spikes, m_spk);
        check("slot", 256'(current_slot), 256'(m_slot));
        check("count", 256'(fifo_count), 256'(q_axon.size()));
        check("ready", 256'(packet_ready), 256'(q_axon.size() != 4));
        check("error", 256'(error), 256'(m_err));
    endtask

    // One clock cycle of stimulus; the model applies the same cycle
    task automatic step(input bit v, input int ax, input int dl,
                        input bit t, input bit s, input bit c);
        bit acc;
        bit pop;
        int a;
        int d;
        packet_valid  = v;
        packet_axon   = 8'(ax);
        packet_delay  = 4'(dl);
        tick          = t;
        scheduler_set = s;
        scheduler_clr = c;
        acc = v && (q_axon.size() != 4);
        pop = (q_axon.size() > 0) && !t;
        @(posedge clk);
        if (s) m_spk = m_rows[m_slot];
        if (c) m_rows[m_slot] = '0;
        if (pop) begin
            a = q_axon.pop_front();
            d = q_delay.pop_front();
            if (d == 15) m_err = 1'b1;
            else m_rows[(m_slot + 1 + d) % 16][a] = 1'b1;
        end
        if (acc) begin
            q_axon.push_back(ax);
            q_delay.push_back(dl);
        end
        if (t) m_slot = (m_slot + 1) % 16;
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Visit every slot with set+clr, leaving all rows empty
    task automatic sweep();
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 1, 0, 0);
        end
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        compare_all();

        // Basic delivery: axon 5, delay 0 lands in slot 1
        step(1, 5, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("basic_set", axon_spikes, 256'(1) << 5);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        check("basic_clr", axon_spikes, 256'(0));

        // Wrap: from slot 15, delay 2 lands in slot 2
        for (int i = 0; i < 16 && m_slot != 15; i++) step(0, 0, 0, 1, 0, 0);
        check("wrap_slot", 256'(current_slot), 256'(15));
        step(1, 200, 2, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("wrap_set", axon_spikes, 256'(1) << 200);

        // Illegal delay: dropped, sticky error
        step(0, 0, 0, 0, 0, 1);
        step(1, 7, 15, 0, 0, 0);
        idle(1);
        check("illegal_err", 256'(error), 256'(1));
        step(0, 0, 0, 0, 1, 0);
        check("illegal_row", axon_spikes, 256'(0));
        step(1, 9, 3, 0, 0, 0);
        step(1, 10, 4, 0, 0, 0);
        idle(2);
        check("err_sticky", 256'(error), 256'(1));

        // Backpressure while tick held high
        for (int i = 0; i < 6; i++)
            step(1, $urandom_range(0, 255), $urandom_range(0, 14), 1, 0, 0);
        check("bp_count", 256'(fifo_count), 256'(4));
        check("bp_ready", 256'(packet_ready), 256'(0));
        idle(5);
        check("bp_drained", 256'(fifo_count), 256'(0));
        sweep();

        // Simultaneous set+clr+tick on a row with bits 0 and 255
        step(1, 0, 0, 0, 0, 0);
        step(1, 255, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        check("sct_set", axon_spikes, (256'(1) << 255) | 256'(1));
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("sct_clr", axon_spikes, 256'(0));

        // Reset mid-drain discards FIFO and rows
        sweep();
        step(1, 11, 1, 1, 0, 0);
        step(1, 12, 2, 1, 0, 0);
        step(1, 13, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        m_reset();
        compare_all();
        check("rst_count", 256'(fifo_count), 256'(0));
        #2 reset = 1'b0;
        sweep();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1),
                 $urandom_range(0, 255),
                 ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 14),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0);
        end
        tick = 1'b0;
        packet_valid = 1'b0;
        scheduler_set = 1'b0;
        scheduler_clr = 1'b0;
        idle(6);
        sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
